// File: rtl/seg_pattern_decoder_if.sv
// Segment bus plus decoded-code outputs of the seven-segment loop-back monitor.
interface seg_pattern_decoder_if #(
    parameter int unsigned ERR_W = 8
);
    logic [7:0]       seg_data;
    logic [2:0]       seg_number;
    logic             code_valid;
    logic             code_known;
    logic             blank;
    logic             stable;
    logic [ERR_W-1:0] err_count;

    modport master (
        output seg_data,
        input  seg_number, code_valid, code_known, blank, stable, err_count
    );

    modport slave (
        input  seg_data,
        output seg_number, code_valid, code_known, blank, stable, err_count
    );
endinterface

// File: rtl/seg_pattern_decoder.sv
// Samples an active-low seven-segment bus, waits for it to settle and decodes
// it back to a 3-bit character code; unknown published patterns are counted.
module seg_pattern_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 3,
    parameter int unsigned ERR_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg_pattern_decoder_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    typedef enum logic {S_LOCKED, S_SETTLE} state_t;

    state_t           state, state_nxt;
    logic [7:0]       seg_q, cand, cand_nxt, pub;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             publish;

    logic [2:0]       seg_number;
    logic             code_valid, code_known, blank, stable;
    logic [ERR_W-1:0] err_count;

    logic [2:0]       dec_num;
    logic             dec_known, dec_blank;

    // Settle FSM: any change of the sampled bus restarts the stability window.
    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        publish   = 1'b0;
        case (state)
            S_LOCKED: begin
                if (seg_q != cand) begin
                    cand_nxt  = seg_q;
                    cnt_nxt   = '0;
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (seg_q != cand) begin
                    cand_nxt = seg_q;
                    cnt_nxt  = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_LOCKED;
                    publish   = (cand != pub);
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = S_LOCKED;
        endcase
    end

    // Full 8-bit match, so a lit decimal point never decodes as a character.
    always_comb begin
        dec_num   = 3'd0;
        dec_known = 1'b0;
        dec_blank = 1'b0;
        case (cand)
            8'hC6: begin dec_num = 3'd1; dec_known = 1'b1; end
            8'h92: begin dec_num = 3'd3; dec_known = 1'b1; end
            8'hCF: begin dec_num = 3'd5; dec_known = 1'b1; end
            8'h86: begin dec_num = 3'd7; dec_known = 1'b1; end
            8'hFF: begin dec_known = 1'b1; dec_blank = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q      <= 8'hFF;
            cand       <= 8'hFF;
            pub        <= 8'hFF;
            cnt        <= '0;
            state      <= S_LOCKED;
            seg_number <= 3'd0;
            code_valid <= 1'b0;
            code_known <= 1'b1;
            blank      <= 1'b1;
            stable     <= 1'b1;
            err_count  <= '0;
        end else begin
            seg_q      <= bus.seg_data;
            cand       <= cand_nxt;
            cnt        <= cnt_nxt;
            state      <= state_nxt;
            stable     <= (state_nxt == S_LOCKED);
            code_valid <= publish;
            if (publish) begin
                pub        <= cand;
                seg_number <= dec_num;
                code_known <= dec_known;
                blank      <= dec_blank;
                if (!dec_known && err_count != ERR_MAX) begin
                    err_count <= err_count + ERR_W'(1);
                end
            end
        end
    end

    assign bus.seg_number = seg_number;
    assign bus.code_valid = code_valid;
    assign bus.code_known = code_known;
    assign bus.blank      = blank;
    assign bus.stable     = stable;
    assign bus.err_count  = err_count;
endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Directed bench for seg_pattern_decoder: expected publishes are queued at
// stimulus time and matched by a monitor whenever code_valid pulses.
module tb_seg_pattern_decoder;
    localparam int unsigned ERR_W = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cyc = 32'd0;
    int          checks = 0;
    int          errors = 0;

    typedef struct packed {
        logic [2:0]       num;
        logic             known;
        logic             blank;
        logic [ERR_W-1:0] err;
        logic [31:0]      cyc;
    } exp_t;

    exp_t exp_q[$];

    seg_pattern_decoder_if #(.ERR_W(ERR_W)) bus ();

    seg_pattern_decoder #(
        .STABLE_CYCLES(4),
        .CNT_W        (3),
        .ERR_W        (ERR_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pulse lands 6 edges after the drive point: capture, enter settle, 4 matching samples.
    task automatic drive(input logic [7:0] pat, input int hold, input bit pub_exp,
                         input logic [2:0] n, input logic k, input logic b,
                         input logic [ERR_W-1:0] e);
        exp_t x;
        bus.seg_data = pat;
        if (pub_exp) begin
            x.num   = n;
            x.known = k;
            x.blank = b;
            x.err   = e;
            x.cyc   = cyc + 32'd6;
            exp_q.push_back(x);
        end
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seg_number"}, 32'(bus.seg_number), 32'd0);
        check({tag, "_code_valid"}, 32'(bus.code_valid), 32'd0);
        check({tag, "_code_known"}, 32'(bus.code_known), 32'd1);
        check({tag, "_blank"},      32'(bus.blank),      32'd1);
        check({tag, "_stable"},     32'(bus.stable),     32'd1);
        check({tag, "_err_count"},  32'(bus.err_count),  32'd0);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (bus.code_valid == 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse", 32'd1, 32'd0);
                    end else begin
                        exp_t x;
                        x = exp_q.pop_front();
                        check("pulse_seg_number", 32'(bus.seg_number), 32'(x.num));
                        check("pulse_code_known", 32'(bus.code_known), 32'(x.known));
                        check("pulse_blank",      32'(bus.blank),      32'(x.blank));
                        check("pulse_err_count",  32'(bus.err_count),  32'(x.err));
                        check("pulse_cycle",      cyc,                 x.cyc);
                    end
                end
            end
        join_none

        // T1 reset with an undriven bus, then all-dark held: no pulse.
        rst_n        = 1'b0;
        bus.seg_data = 8'hxx;
        wait_cycles(3);
        check_reset_outputs("t1_reset");
        bus.seg_data = 8'hFF;
        wait_cycles(1);
        rst_n = 1'b1;
        wait_cycles(10);
        check("t1_idle_stable", 32'(bus.stable), 32'd1);

        // T2 the four known characters.
        drive(8'hC6, 8, 1'b1, 3'd1, 1'b1, 1'b0, 2'd0);
        drive(8'h92, 8, 1'b1, 3'd3, 1'b1, 1'b0, 2'd0);
        drive(8'hCF, 8, 1'b1, 3'd5, 1'b1, 1'b0, 2'd0);
        drive(8'h86, 8, 1'b1, 3'd7, 1'b1, 1'b0, 2'd0);

        // T3 glitch back to the settled value: stable drops, nothing published.
        drive(8'hC6, 8, 1'b1, 3'd1, 1'b1, 1'b0, 2'd0);
        drive(8'h92, 2, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0);
        check("t3_stable_low", 32'(bus.stable), 32'd0);
        drive(8'hC6, 10, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0);
        check("t3_stable_back",  32'(bus.stable),     32'd1);
        check("t3_seg_number",   32'(bus.seg_number), 32'd1);

        // T4 unknown pattern then blank.
        drive(8'h00, 8, 1'b1, 3'd0, 1'b0, 1'b0, 2'd1);
        drive(8'hFF, 8, 1'b1, 3'd0, 1'b1, 1'b1, 2'd1);

        // T5 saturation of the 2-bit unknown counter, from a fresh reset.
        rst_n = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(2);
        check("t5_err_cleared", 32'(bus.err_count), 32'd0);
        drive(8'h00, 8, 1'b1, 3'd0, 1'b0, 1'b0, 2'd1);
        drive(8'hFF, 8, 1'b1, 3'd0, 1'b1, 1'b1, 2'd1);
        drive(8'h00, 8, 1'b1, 3'd0, 1'b0, 1'b0, 2'd2);
        drive(8'hFF, 8, 1'b1, 3'd0, 1'b1, 1'b1, 2'd2);
        drive(8'h00, 8, 1'b1, 3'd0, 1'b0, 1'b0, 2'd3);
        drive(8'hFF, 8, 1'b1, 3'd0, 1'b1, 1'b1, 2'd3);
        drive(8'h00, 8, 1'b1, 3'd0, 1'b0, 1'b0, 2'd3);
        drive(8'hFF, 8, 1'b1, 3'd0, 1'b1, 1'b1, 2'd3);
        drive(8'h00, 8, 1'b1, 3'd0, 1'b0, 1'b0, 2'd3);
        check("t5_err_saturated", 32'(bus.err_count), 32'd3);
        drive(8'hFF, 8, 1'b1, 3'd0, 1'b1, 1'b1, 2'd3);

        // T6 reset in the third settle cycle: the interrupted pattern never publishes.
        drive(8'h86, 4, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0);
        check("t6_settling", 32'(bus.stable), 32'd0);
        rst_n        = 1'b0;
        bus.seg_data = 8'hFF;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(12);
        check_reset_outputs("t6_after");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) wait_cycles(1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
